// File: rtl/mem_view_pkg.sv
// Shared types for the memory-view read sequencer: FSM states and source encoding.
package mem_view_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        WAIT    = 2'd2,
        CAPTURE = 2'd3
    } state_e;

    localparam logic SRC_IMEM = 1'b0;
    localparam logic SRC_DMEM = 1'b1;

endpackage

// File: rtl/btn_debounce.sv
// Board button conditioner: 2-flop synchronizer, stability counter, one-cycle press pulse.
module btn_debounce #(
    parameter int DEB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic press_o
);

    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             press_q;
    logic [CNT_W-1:0] cnt_q;

    // Bring the raw pin into the clock domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
        end
    end

    // Accept a new level only after DEB_CYCLES consecutive differing samples; pulse on accepted press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
            press_q  <= 1'b0;
        end else begin
            press_q <= 1'b0;
            if (sync2_q == stable_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                cnt_q    <= '0;
                stable_q <= sync2_q;
                press_q  <= sync2_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/mem_view_sequencer.sv
// Read sequencer that fetches one word of IMEM or DMEM per button/auto event and holds it for display.
module mem_view_sequencer
    import mem_view_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int RD_LAT     = 1,
    parameter int DEB_CYCLES = 1000000,
    parameter int DWELL      = 50000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btn_next,
    input  logic              btn_sel,
    input  logic              auto_en,
    output logic              imem_rd,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_data,
    output logic              dmem_rd,
    output logic [ADDR_W-1:0] dmem_addr,
    input  logic [DATA_W-1:0] dmem_data,
    output logic [DATA_W-1:0] disp_word,
    output logic [ADDR_W-1:0] disp_addr,
    output logic              disp_src,
    output logic              disp_valid
);

    localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);
    // WAIT runs RD_LAT-1 cycles, counted 0..RD_LAT-2.
    localparam logic [1:0] WAIT_LAST = 2'((RD_LAT > 1) ? RD_LAT - 2 : 0);

    logic next_pulse;
    logic sel_pulse;

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic              src_q;
    logic              boot_q;
    logic              pend_next_q;
    logic              pend_sel_q;
    logic [1:0]        wait_q;
    logic [DW_W-1:0]   dwell_q;
    logic              imem_rd_q;
    logic              dmem_rd_q;
    logic [DATA_W-1:0] disp_word_q;
    logic [ADDR_W-1:0] disp_addr_q;
    logic              disp_src_q;
    logic              disp_valid_q;

    logic              auto_fire_d;
    logic              take_next_d;
    logic              take_sel_d;
    logic              take_any_d;
    logic              src_d;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_next (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_i   (btn_next),
        .press_o (next_pulse)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_sel (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_i   (btn_sel),
        .press_o (sel_pulse)
    );

    // Merge fresh pulses, pending flags, the auto-step tick and the post-reset fetch.
    always_comb begin
        auto_fire_d = auto_en && (state_q == IDLE) && (dwell_q == DWELL_LAST);
        take_next_d = next_pulse || pend_next_q || auto_fire_d;
        take_sel_d  = sel_pulse || pend_sel_q;
        take_any_d  = take_next_d || take_sel_d || boot_q;
        src_d       = src_q ^ take_sel_d;
    end

    // Sequencer FSM with address/source and display registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            boot_q       <= 1'b1;
            addr_q       <= '0;
            src_q        <= SRC_IMEM;
            pend_next_q  <= 1'b0;
            pend_sel_q   <= 1'b0;
            wait_q       <= '0;
            imem_rd_q    <= 1'b0;
            dmem_rd_q    <= 1'b0;
            disp_word_q  <= '0;
            disp_addr_q  <= '0;
            disp_src_q   <= SRC_IMEM;
            disp_valid_q <= 1'b0;
        end else begin
            imem_rd_q <= 1'b0;
            dmem_rd_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (take_any_d) begin
                        state_q      <= READ;
                        boot_q       <= 1'b0;
                        pend_next_q  <= 1'b0;
                        pend_sel_q   <= 1'b0;
                        addr_q       <= take_next_d ? addr_q + 1'b1 : addr_q;
                        src_q        <= src_d;
                        imem_rd_q    <= (src_d == SRC_IMEM);
                        dmem_rd_q    <= (src_d == SRC_DMEM);
                        disp_valid_q <= 1'b0;
                    end
                end
                READ: begin
                    wait_q  <= '0;
                    state_q <= (RD_LAT > 1) ? WAIT : CAPTURE;
                end
                WAIT: begin
                    if (wait_q == WAIT_LAST) begin
                        state_q <= CAPTURE;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                CAPTURE: begin
                    disp_word_q  <= (src_q == SRC_DMEM) ? dmem_data : imem_data;
                    disp_addr_q  <= addr_q;
                    disp_src_q   <= src_q;
                    disp_valid_q <= 1'b1;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
            if (state_q != IDLE) begin
                if (next_pulse) pend_next_q <= 1'b1;
                if (sel_pulse)  pend_sel_q  <= 1'b1;
            end
        end
    end

    // Auto-step dwell counter: runs only while idle with auto enabled; any manual press restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell_q <= '0;
        end else if (!auto_en || next_pulse || sel_pulse) begin
            dwell_q <= '0;
        end else if (state_q == IDLE) begin
            dwell_q <= take_any_d ? '0 : dwell_q + 1'b1;
        end
    end

    assign imem_rd    = imem_rd_q;
    assign dmem_rd    = dmem_rd_q;
    assign imem_addr  = addr_q;
    assign dmem_addr  = addr_q;
    assign disp_word  = disp_word_q;
    assign disp_addr  = disp_addr_q;
    assign disp_src   = disp_src_q;
    assign disp_valid = disp_valid_q;

endmodule

// File: tb/tb_mem_view_sequencer.sv
// Directed bench for mem_view_sequencer: one instance at RD_LAT=1, one at RD_LAT=3.
module tb_mem_view_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Instance 1: RD_LAT=1, DEB_CYCLES=4, DWELL=10
    logic        rst1_n, next1, sel1, auto1;
    logic        i_rd1, d_rd1, s1, v1;
    logic [7:0]  i_addr1, d_addr1, a1;
    logic [31:0] i_data1 = '0, d_data1 = '0, w1;

    // Instance 3: RD_LAT=3, DEB_CYCLES=1, DWELL=10
    logic        rst3_n, next3, sel3, auto3;
    logic        i_rd3, d_rd3, s3, v3;
    logic [7:0]  i_addr3, d_addr3, a3;
    logic [31:0] i_data3 = '0, d_data3 = '0, w3;
    logic [31:0] ip1 = '0, ip2 = '0, dp1 = '0, dp2 = '0;

    mem_view_sequencer #(.ADDR_W(8), .DATA_W(32), .RD_LAT(1), .DEB_CYCLES(4), .DWELL(10)) dut1 (
        .clk(clk), .rst_n(rst1_n), .btn_next(next1), .btn_sel(sel1), .auto_en(auto1),
        .imem_rd(i_rd1), .imem_addr(i_addr1), .imem_data(i_data1),
        .dmem_rd(d_rd1), .dmem_addr(d_addr1), .dmem_data(d_data1),
        .disp_word(w1), .disp_addr(a1), .disp_src(s1), .disp_valid(v1)
    );

    mem_view_sequencer #(.ADDR_W(8), .DATA_W(32), .RD_LAT(3), .DEB_CYCLES(1), .DWELL(10)) dut3 (
        .clk(clk), .rst_n(rst3_n), .btn_next(next3), .btn_sel(sel3), .auto_en(auto3),
        .imem_rd(i_rd3), .imem_addr(i_addr3), .imem_data(i_data3),
        .dmem_rd(d_rd3), .dmem_addr(d_addr3), .dmem_data(d_data3),
        .disp_word(w3), .disp_addr(a3), .disp_src(s3), .disp_valid(v3)
    );

    function automatic logic [31:0] imem_word(input logic [7:0] a);
        return (a == 8'd0) ? 32'hDEADBEEF : {24'hA1A100, a};
    endfunction

    function automatic logic [31:0] dmem_word(input logic [7:0] a);
        return {24'hD0D000, a};
    endfunction

    // Memory models: latency 1 and latency 3
    always @(posedge clk) begin
        if (i_rd1) i_data1 <= imem_word(i_addr1);
        if (d_rd1) d_data1 <= dmem_word(d_addr1);
        if (i_rd3) ip1 <= imem_word(i_addr3);
        if (d_rd3) dp1 <= dmem_word(d_addr3);
        ip2 <= ip1;
        dp2 <= dp1;
        i_data3 <= ip2;
        d_data3 <= dp2;
    end

    // Read monitors: count strobes, flag back-to-back or dual strobes
    int   rdcnt1 = 0, b2b1 = 0, rdcnt3 = 0, b2b3 = 0;
    logic prev1 = 1'b0, prev3 = 1'b0;
    always @(posedge clk) begin
        if (!rst1_n) begin
            prev1 <= 1'b0;
        end else begin
            if (i_rd1 | d_rd1) rdcnt1 <= rdcnt1 + 1;
            if (((i_rd1 | d_rd1) && prev1) || (i_rd1 && d_rd1)) b2b1 <= b2b1 + 1;
            prev1 <= i_rd1 | d_rd1;
        end
        if (!rst3_n) begin
            prev3 <= 1'b0;
        end else begin
            if (i_rd3 | d_rd3) rdcnt3 <= rdcnt3 + 1;
            if (((i_rd3 | d_rd3) && prev3) || (i_rd3 && d_rd3)) b2b3 <= b2b3 + 1;
            prev3 <= i_rd3 | d_rd3;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rd1(input int max, output int n);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            tick();
            if (i_rd1 | d_rd1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic wait_rd3(input int max, output int n);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            tick();
            if (i_rd3 | d_rd3) begin
                n = i;
                break;
            end
        end
    endtask

    // Hold the selected buttons of instance 1 for 6 cycles; return edges until a read strobe.
    task automatic press1(input logic nx, input logic sl, output int n);
        next1 = nx;
        sel1  = sl;
        n     = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (i == 6) begin
                next1 = 1'b0;
                sel1  = 1'b0;
            end
            if (i_rd1 | d_rd1) begin
                n = i;
                break;
            end
        end
        next1 = 1'b0;
        sel1  = 1'b0;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base;
        int hit;
        rst1_n = 1'b0; next1 = 1'b0; sel1 = 1'b0; auto1 = 1'b0;
        rst3_n = 1'b0; next3 = 1'b0; sel3 = 1'b0; auto3 = 1'b0;
        repeat (3) tick();

        chk("rst_imem_rd",  64'(i_rd1), 64'(0));
        chk("rst_dmem_rd",  64'(d_rd1), 64'(0));
        chk("rst_addr",     64'(i_addr1), 64'(0));
        chk("rst_word",     64'(w1), 64'(0));
        chk("rst_valid",    64'(v1), 64'(0));

        // Boot fetch of IMEM[0]
        rst1_n = 1'b1;
        tick();
        chk("boot_imem_rd", 64'(i_rd1), 64'(1));
        chk("boot_dmem_rd", 64'(d_rd1), 64'(0));
        chk("boot_addr",    64'(i_addr1), 64'(0));
        tick();
        chk("boot_rd_drop", 64'(i_rd1), 64'(0));
        chk("boot_valid_lo", 64'(v1), 64'(0));
        tick();
        chk("boot_word",    64'(w1), 64'hDEADBEEF);
        chk("boot_src",     64'(s1), 64'(0));
        chk("boot_daddr",   64'(a1), 64'(0));
        chk("boot_valid",   64'(v1), 64'(1));
        repeat (3) tick();

        // Debounced next press: 2 sync + 4 stable + 1 FSM edge
        press1(1'b1, 1'b0, n);
        chk("next_latency", 64'(n), 64'(7));
        chk("next_imem_rd", 64'(i_rd1), 64'(1));
        chk("next_addr",    64'(i_addr1), 64'(1));
        tick();
        tick();
        chk("next_word",    64'(w1), 64'hA1A10001);
        chk("next_daddr",   64'(a1), 64'(1));
        repeat (10) tick();
        base = rdcnt1;

        // 3-cycle glitch must be rejected
        next1 = 1'b1;
        repeat (3) tick();
        next1 = 1'b0;
        repeat (15) tick();
        chk("glitch_reads", 64'(rdcnt1 - base), 64'(0));

        // Auto stepping from address 1 up to 5
        auto1 = 1'b1;
        wait_rd1(20, n);
        chk("auto_first",   64'(n), 64'(10));
        chk("auto_addr2",   64'(i_addr1), 64'(2));
        wait_rd1(20, n);
        chk("auto_period",  64'(n), 64'(12));
        chk("auto_addr3",   64'(i_addr1), 64'(3));
        wait_rd1(20, n);
        wait_rd1(20, n);
        chk("auto_addr5",   64'(i_addr1), 64'(5));
        auto1 = 1'b0;
        repeat (3) tick();
        chk("auto_daddr5",  64'(a1), 64'(5));
        chk("auto_word5",   64'(w1), 64'hA1A10005);
        repeat (5) tick();

        // next and sel in the same cycle
        press1(1'b1, 1'b1, n);
        chk("both_latency", 64'(n), 64'(7));
        chk("both_dmem_rd", 64'(d_rd1), 64'(1));
        chk("both_imem_rd", 64'(i_rd1), 64'(0));
        chk("both_daddr",   64'(d_addr1), 64'(6));
        chk("both_iaddr",   64'(i_addr1), 64'(6));
        tick();
        tick();
        chk("both_word",    64'(w1), 64'hD0D00006);
        chk("both_src",     64'(s1), 64'(1));
        chk("both_disp_a",  64'(a1), 64'(6));
        repeat (10) tick();

        // Auto-step DMEM up to 0xFF
        auto1 = 1'b1;
        hit = 0;
        for (int k = 0; k < 300; k++) begin
            wait_rd1(20, n);
            if (n < 0) break;
            if (d_addr1 == 8'hFF) begin
                hit = 1;
                break;
            end
        end
        auto1 = 1'b0;
        chk("auto_reach_ff", 64'(hit), 64'(1));
        chk("auto_gap_ff",   64'(n), 64'(12));
        repeat (3) tick();
        chk("ff_daddr",     64'(a1), 64'hFF);
        chk("ff_word",      64'(w1), 64'hD0D000FF);
        repeat (5) tick();

        // Wrap 0xFF -> 0x00
        press1(1'b1, 1'b0, n);
        chk("wrap_latency", 64'(n), 64'(7));
        chk("wrap_dmem_rd", 64'(d_rd1), 64'(1));
        chk("wrap_daddr",   64'(d_addr1), 64'(0));
        chk("wrap_iaddr",   64'(i_addr1), 64'(0));
        tick();
        tick();
        chk("wrap_disp_a",  64'(a1), 64'(0));
        chk("wrap_word",    64'(w1), 64'hD0D00000);
        chk("wrap_valid",   64'(v1), 64'(1));
        tick();
        chk("total_reads1", 64'(rdcnt1), 64'(257));
        chk("b2b_reads1",   64'(b2b1), 64'(0));

        // Instance 3: boot with RD_LAT=3
        rst3_n = 1'b1;
        tick();
        chk("l3_boot_rd",   64'(i_rd3), 64'(1));
        chk("l3_boot_addr", 64'(i_addr3), 64'(0));
        repeat (3) tick();
        chk("l3_cap_valid", 64'(v3), 64'(0));
        tick();
        chk("l3_boot_word", 64'(w3), 64'hDEADBEEF);
        chk("l3_boot_valid", 64'(v3), 64'(1));

        // Three presses while busy collapse into one pending read
        base = rdcnt3;
        next3 = 1'b1; tick(); next3 = 1'b0; tick();
        next3 = 1'b1; tick(); next3 = 1'b0; tick();
        next3 = 1'b1; tick(); next3 = 1'b0;
        repeat (15) tick();
        chk("l3_burst_reads", 64'(rdcnt3 - base), 64'(2));
        chk("l3_burst_addr",  64'(i_addr3), 64'(2));
        chk("l3_burst_daddr", 64'(a3), 64'(2));
        chk("l3_burst_word",  64'(w3), 64'hA1A10002);

        // Asynchronous reset during WAIT
        next3 = 1'b1;
        tick();
        next3 = 1'b0;
        wait_rd3(10, n);
        chk("l3_trig_lat",  64'(n), 64'(3));
        tick();
        rst3_n = 1'b0;
        #1;
        chk("l3_rst_rd",    64'({i_rd3, d_rd3}), 64'(0));
        chk("l3_rst_addr",  64'({i_addr3, d_addr3}), 64'(0));
        chk("l3_rst_word",  64'(w3), 64'(0));
        chk("l3_rst_disp",  64'({a3, s3, v3}), 64'(0));
        tick();
        tick();
        rst3_n = 1'b1;
        tick();
        chk("l3_refetch_rd",   64'(i_rd3), 64'(1));
        chk("l3_refetch_addr", 64'(i_addr3), 64'(0));
        repeat (4) tick();
        chk("l3_refetch_word", 64'(w3), 64'hDEADBEEF);
        chk("l3_refetch_valid", 64'(v3), 64'(1));
        chk("b2b_reads3",   64'(b2b3), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
